// File: rtl/serial_cla_adder.sv
// Digit-serial adder: one 4-bit carry-lookahead slice walks the operands a nibble per cycle.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.

module claAdder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    // Carries are flattened generate/propagate terms so none waits on a lower carry.
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[1] = g[0] | (p[0] & c_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_i);
        s_o  = p ^ {c[3], c[2], c[1], c_i};
        c_o  = c[4];
    end
endmodule

module serial_cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int N  = WIDTH / 4;
    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [3:0] nibA;
    logic [3:0] nibB;
    logic [3:0] nibSum;
    logic       nibCarry;

    assign nibA = a_q[{k_q, 2'b00} +: 4];
    assign nibB = b_q[{k_q, 2'b00} +: 4];

    claAdder4 uSlice (
        .a_i (nibA),
        .b_i (nibB),
        .c_i (carry_q),
        .s_o (nibSum),
        .c_o (nibCarry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        s_d       = s_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = c_in;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[{k_q, 2'b00} +: 4] = nibSum;
                carry_d = nibCarry;
                // The counter parks on the last nibble instead of wrapping back to zero.
                if (k_q == LAST_K) begin
                    cout_d  = nibCarry;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nibSum[3] != a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s     = s_q;
    assign c_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_cla_adder.sv
// Directed and random checks of serial_cla_adder at WIDTH=32; all driving and sampling on the falling edge.
// Define SERIAL_ADD_OVF_EN to also check the ovf output.

module tb_serial_cla_adder;
    localparam int WIDTH = 32;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts falling edges until out_valid rises; returns the bound on timeout so the latency check fails.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input int inGap, input int outGap,
                                 input logic [32:0] expSum, input logic expOvf);
        int lat;
        repeat (inGap) @(negedge clk);
        checkOutput("in_ready idle", 64'(in_ready), 64'(1'b1));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        c_in     = cin;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        c_in     = 1'($urandom);
        waitResult(lat);
        checkOutput("latency", 64'(lat), 64'(N));
        checkOutput("sum", 64'({c_out, s}), 64'(expSum));
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("ovf", 64'(ovf), 64'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] unexpected X in expected ovf");
`endif
        checkOutput("in_ready busy", 64'(in_ready), 64'(1'b0));
        for (int i = 0; i < outGap; i++) begin
            @(negedge clk);
            checkOutput("hold", 64'({out_valid, c_out, s}), 64'({1'b1, expSum}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid drop", 64'(out_valid), 64'(1'b0));
        checkOutput("in_ready back", 64'(in_ready), 64'(1'b1));
    endtask

    initial begin
        int lat;
        int stale;
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] rsum;
        logic        rovf;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        c_in      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset in_ready", 64'(in_ready), 64'(1'b1));
        checkOutput("reset out_valid", 64'(out_valid), 64'(1'b0));
        checkOutput("reset sum", 64'({c_out, s}), 64'(0));

        // Directed vectors with hand-computed {c_out,s} and ovf.
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 0, 33'h1_00000000, 1'b0);
        applyStimulus(32'h12345678, 32'h11111111, 1'b1, 1, 1, 33'h0_2345678A, 1'b0);
        applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 2, 33'h0_80000000, 1'b1);
        applyStimulus(32'h00000000, 32'h00000000, 1'b0, 0, 0, 33'h0_00000000, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2, 0, 33'h1_FFFFFFFF, 1'b0);
        applyStimulus(32'h80000000, 32'h80000000, 1'b0, 0, 1, 33'h1_00000000, 1'b1);
        applyStimulus(32'h0000000F, 32'h00000001, 1'b0, 0, 0, 33'h0_00000010, 1'b0);

        // Backpressure with a competing request held on in_valid.
        in_valid = 1'b1;
        in_a     = 32'hA5A5A5A5;
        in_b     = 32'h5A5A5A5A;
        c_in     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waitResult(lat);
        checkOutput("bp latency", 64'(lat), 64'(N));
        in_valid = 1'b1;
        in_a     = 32'h00000100;
        in_b     = 32'h00000023;
        c_in     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp hold", 64'({out_valid, c_out, s}), 64'({1'b1, 33'h1_00000000}));
            checkOutput("bp in_ready", 64'(in_ready), 64'(1'b0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp released", 64'({out_valid, in_ready}), 64'(2'b01));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waitResult(lat);
        checkOutput("bp second latency", 64'(lat), 64'(N));
        checkOutput("bp second sum", 64'({c_out, s}), 64'(33'h0_00000123));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset lands on the fourth edge after the accept edge, mid-RUN.
        in_valid = 1'b1;
        in_a     = 32'hFFFFFFFF;
        in_b     = 32'hFFFFFFFF;
        c_in     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrun out_valid", 64'(out_valid), 64'(1'b0));
        checkOutput("midrun sum", 64'({c_out, s}), 64'(0));
        checkOutput("midrun in_ready", 64'(in_ready), 64'(1'b1));
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("midrun no stale", 64'(stale), 64'(0));

        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom);
            rsum = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            rovf = (ra[31] == rb[31]) && (rsum[31] != ra[31]);
            applyStimulus(ra, rb, rc, $urandom_range(0, 2), $urandom_range(0, 3), rsum, rovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
